// File: rtl/fcr_cmd_rx.sv
// Host-link command receiver: packs rx bytes big-endian into 32-bit words and queues them in a FIFO.
// Latency: word visible (cmd_waitreq low) 1 cycle after its 4th byte; popped word on cmd_data 1 cycle after cmd_rdreq.
// Backpressure: none on rx_valid; a word completed while the FIFO is full is dropped and flagged via overflow.
// Optional inter-byte timeout enabled by defining FCR_CMD_RX_TIMEOUT_EN.
module fcr_cmd_rx #(
    parameter int DEPTH_LOG2     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic [31:0]           cmd_data,
    output logic                  cmd_waitreq,
    input  logic                  cmd_rdreq,
    output logic [DEPTH_LOG2:0]   fill_level,
    output logic                  overflow,
    output logic                  timeout_err,
    input  logic                  clr_flags
);

    localparam int                  DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL  = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [1:0]            byte_cnt;
    logic [23:0]           asm_q;
    logic [31:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   fill;
    logic [31:0]           cmd_q;
    logic                  ovf_q;

    logic                  timeout_hit;
    logic                  word_done;
    logic                  is_full;
    logic                  is_empty;
    logic                  do_push;
    logic                  do_pop;
    logic                  drop;
    logic [31:0]           word;

`ifdef FCR_CMD_RX_TIMEOUT_EN
    logic [15:0] to_cnt;
    logic        to_err_q;

    // Timeout fires on the edge that ends the TIMEOUT_CYCLES-th idle cycle of a partial word;
    // a byte arriving in that cycle makes it non-idle, so the byte wins.
    always_comb begin
        timeout_hit = (byte_cnt != 2'd0) && !rx_valid &&
                      (to_cnt == 16'(TIMEOUT_CYCLES - 1));
    end

    // Idle-cycle counter, only running while a word is partially assembled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= 16'd0;
        end else if (rx_valid || byte_cnt == 2'd0 || timeout_hit) begin
            to_cnt <= 16'd0;
        end else begin
            to_cnt <= to_cnt + 16'd1;
        end
    end

    // Sticky timeout flag; a new timeout beats a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_err_q <= 1'b0;
        end else if (timeout_hit) begin
            to_err_q <= 1'b1;
        end else if (clr_flags) begin
            to_err_q <= 1'b0;
        end
    end

    assign timeout_err = to_err_q;
`else
    localparam int timeout_unused = TIMEOUT_CYCLES;

    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // FIFO control: a pop on empty is ignored, so push+pop on empty degenerates to a push;
    // on full, a same-cycle pop frees the slot the push needs.
    always_comb begin
        word      = {asm_q, rx_data};
        word_done = rx_valid && (byte_cnt == 2'd3);
        is_full   = (fill == FULL);
        is_empty  = (fill == '0);
        do_pop    = cmd_rdreq && !is_empty;
        do_push   = word_done && (!is_full || do_pop);
        drop      = word_done && is_full && !do_pop;
    end

    // Byte assembly: earlier bytes shift toward the MSBs, so the 4th byte lands in bits 7:0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt <= 2'd0;
            asm_q    <= 24'd0;
        end else if (timeout_hit) begin
            byte_cnt <= 2'd0;
        end else if (rx_valid) begin
            byte_cnt <= byte_cnt + 2'd1;
            asm_q    <= {asm_q[15:0], rx_data};
        end
    end

    // Storage array has no reset; only the pointers and fill count define its contents.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= word;
        end
    end

    // Pointers, fill count and the registered read port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
            cmd_q  <= 32'd0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                cmd_q  <= mem[rd_ptr];
            end
            case ({do_push, do_pop})
                2'b10:   fill <= fill + 1'b1;
                2'b01:   fill <= fill - 1'b1;
                default: fill <= fill;
            endcase
        end
    end

    // Sticky overflow flag; a drop beats a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (drop) begin
            ovf_q <= 1'b1;
        end else if (clr_flags) begin
            ovf_q <= 1'b0;
        end
    end

    assign cmd_data    = cmd_q;
    assign cmd_waitreq = is_empty;
    assign fill_level  = fill;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_fcr_cmd_rx.sv
module tb_fcr_cmd_rx;

    localparam int TO = 20;

    logic        clk;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [31:0] cmd_data;
    logic        cmd_waitreq;
    logic        cmd_rdreq;
    logic [4:0]  fill_level;
    logic        overflow;
    logic        timeout_err;
    logic        clr_flags;

    int errors;
    int checks;

    fcr_cmd_rx #(.DEPTH_LOG2(4), .TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .cmd_data    (cmd_data),
        .cmd_waitreq (cmd_waitreq),
        .cmd_rdreq   (cmd_rdreq),
        .fill_level  (fill_level),
        .overflow    (overflow),
        .timeout_err (timeout_err),
        .clr_flags   (clr_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic rd, input logic clr);
        rx_data   = b;
        rx_valid  = 1'b1;
        cmd_rdreq = rd;
        clr_flags = clr;
        tick();
        rx_valid  = 1'b0;
        cmd_rdreq = 1'b0;
        clr_flags = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[31:24], 1'b0, 1'b0);
        send_byte(w[23:16], 1'b0, 1'b0);
        send_byte(w[15:8],  1'b0, 1'b0);
        send_byte(w[7:0],   1'b0, 1'b0);
    endtask

    task automatic pop();
        cmd_rdreq = 1'b1;
        tick();
        cmd_rdreq = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        checks++; if (cmd_data !== 32'd0)   begin errors++; $display("FAIL reset_cmd_data got=%h exp=0", cmd_data); end
        checks++; if (cmd_waitreq !== 1'b1) begin errors++; $display("FAIL reset_waitreq got=%b exp=1", cmd_waitreq); end
        checks++; if (fill_level !== 5'd0)  begin errors++; $display("FAIL reset_fill got=%0d exp=0", fill_level); end
        checks++; if (overflow !== 1'b0)    begin errors++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err got=%b exp=0", timeout_err); end
    endtask

    task automatic test_basic();
        send_byte(8'h00, 1'b0, 1'b0);
        send_byte(8'h02, 1'b0, 1'b0);
        send_byte(8'h00, 1'b0, 1'b0);
        checks++; if (cmd_waitreq !== 1'b1) begin errors++; $display("FAIL basic_partial_waitreq got=%b exp=1", cmd_waitreq); end
        send_byte(8'h01, 1'b0, 1'b0);
        checks++; if (cmd_waitreq !== 1'b0) begin errors++; $display("FAIL basic_waitreq got=%b exp=0", cmd_waitreq); end
        checks++; if (fill_level !== 5'd1)  begin errors++; $display("FAIL basic_fill got=%0d exp=1", fill_level); end
        pop();
        checks++; if (cmd_data !== 32'h0002_0001) begin errors++; $display("FAIL basic_data got=%h exp=00020001", cmd_data); end
        checks++; if (cmd_waitreq !== 1'b1) begin errors++; $display("FAIL basic_waitreq_after_pop got=%b exp=1", cmd_waitreq); end
        checks++; if (fill_level !== 5'd0)  begin errors++; $display("FAIL basic_fill_after_pop got=%0d exp=0", fill_level); end
    endtask

    task automatic test_empty_pop();
        pop();
        checks++; if (cmd_data !== 32'h0002_0001) begin errors++; $display("FAIL empty_pop_data got=%h exp=00020001", cmd_data); end
        checks++; if (fill_level !== 5'd0)  begin errors++; $display("FAIL empty_pop_fill got=%0d exp=0", fill_level); end
        checks++; if (cmd_waitreq !== 1'b1) begin errors++; $display("FAIL empty_pop_waitreq got=%b exp=1", cmd_waitreq); end
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 16; i++) send_word(32'hC0DE_0000 + 32'(i));
        checks++; if (fill_level !== 5'd16) begin errors++; $display("FAIL ovf_fill16 got=%0d exp=16", fill_level); end
        checks++; if (overflow !== 1'b0)    begin errors++; $display("FAIL ovf_not_yet got=%b exp=0", overflow); end
        // 17th word, last byte coincides with clr_flags: the drop must win
        send_byte(8'hC0, 1'b0, 1'b0);
        send_byte(8'hDE, 1'b0, 1'b0);
        send_byte(8'h00, 1'b0, 1'b0);
        send_byte(8'h11, 1'b0, 1'b1);
        checks++; if (overflow !== 1'b1)    begin errors++; $display("FAIL ovf_set_over_clr got=%b exp=1", overflow); end
        checks++; if (fill_level !== 5'd16) begin errors++; $display("FAIL ovf_fill_held got=%0d exp=16", fill_level); end
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        checks++; if (overflow !== 1'b0)    begin errors++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
    endtask

    task automatic test_full_push_pop();
        logic [31:0] exp;
        send_byte(8'h12, 1'b0, 1'b0);
        send_byte(8'h34, 1'b0, 1'b0);
        send_byte(8'h56, 1'b0, 1'b0);
        send_byte(8'h78, 1'b1, 1'b0);
        checks++; if (cmd_data !== 32'hC0DE_0001) begin errors++; $display("FAIL full_pp_data got=%h exp=c0de0001", cmd_data); end
        checks++; if (fill_level !== 5'd16) begin errors++; $display("FAIL full_pp_fill got=%0d exp=16", fill_level); end
        checks++; if (overflow !== 1'b0)    begin errors++; $display("FAIL full_pp_overflow got=%b exp=0", overflow); end
        for (int i = 2; i <= 17; i++) begin
            exp = (i == 17) ? 32'h1234_5678 : 32'hC0DE_0000 + 32'(i);
            pop();
            checks++; if (cmd_data !== exp) begin errors++; $display("FAIL drain_%0d got=%h exp=%h", i, cmd_data, exp); end
        end
        checks++; if (cmd_waitreq !== 1'b1) begin errors++; $display("FAIL drain_empty got=%b exp=1", cmd_waitreq); end
    endtask

    task automatic test_empty_push_pop();
        send_byte(8'h0B, 1'b0, 1'b0);
        send_byte(8'hAD, 1'b0, 1'b0);
        send_byte(8'hBE, 1'b0, 1'b0);
        send_byte(8'hEF, 1'b1, 1'b0);
        checks++; if (fill_level !== 5'd1)  begin errors++; $display("FAIL empty_pp_fill got=%0d exp=1", fill_level); end
        checks++; if (cmd_data !== 32'h1234_5678) begin errors++; $display("FAIL empty_pp_data got=%h exp=12345678", cmd_data); end
        pop();
        checks++; if (cmd_data !== 32'h0BAD_BEEF) begin errors++; $display("FAIL empty_pp_pop got=%h exp=0badbeef", cmd_data); end
    endtask

    task automatic test_timeout();
        send_byte(8'h11, 1'b0, 1'b0);
        send_byte(8'h22, 1'b0, 1'b0);
`ifdef FCR_CMD_RX_TIMEOUT_EN
        // one idle cycle short of the limit: the next byte still counts
        for (int i = 0; i < TO - 1; i++) tick();
        send_byte(8'h33, 1'b0, 1'b0);
        send_byte(8'h44, 1'b0, 1'b0);
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_boundary_err got=%b exp=0", timeout_err); end
        pop();
        checks++; if (cmd_data !== 32'h1122_3344) begin errors++; $display("FAIL to_boundary_data got=%h exp=11223344", cmd_data); end
        send_byte(8'h55, 1'b0, 1'b0);
        send_byte(8'h66, 1'b0, 1'b0);
        for (int i = 0; i < TO; i++) tick();
        send_word(32'hAABB_CCDD);
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_err got=%b exp=1", timeout_err); end
        checks++; if (fill_level !== 5'd1)  begin errors++; $display("FAIL to_fill got=%0d exp=1", fill_level); end
        pop();
        checks++; if (cmd_data !== 32'hAABB_CCDD) begin errors++; $display("FAIL to_data got=%h exp=aabbccdd", cmd_data); end
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_clear got=%b exp=0", timeout_err); end
`else
        // no timeout logic: a long gap leaves the partial word intact
        for (int i = 0; i < TO + 5; i++) tick();
        send_byte(8'h33, 1'b0, 1'b0);
        send_byte(8'h44, 1'b0, 1'b0);
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL nto_err got=%b exp=0", timeout_err); end
        checks++; if (fill_level !== 5'd1)  begin errors++; $display("FAIL nto_fill got=%0d exp=1", fill_level); end
        pop();
        checks++; if (cmd_data !== 32'h1122_3344) begin errors++; $display("FAIL nto_data got=%h exp=11223344", cmd_data); end
`endif
    endtask

    task automatic test_reset_mid();
        send_word(32'hDEAD_0001);
        send_word(32'hDEAD_0002);
        send_word(32'hDEAD_0003);
        send_byte(8'h99, 1'b0, 1'b0);
        send_byte(8'h88, 1'b0, 1'b0);
        checks++; if (fill_level !== 5'd3) begin errors++; $display("FAIL rst_pre_fill got=%0d exp=3", fill_level); end
        rst_n = 1'b0;
        #2;
        checks++; if (fill_level !== 5'd0)  begin errors++; $display("FAIL rst_async_fill got=%0d exp=0", fill_level); end
        checks++; if (cmd_waitreq !== 1'b1) begin errors++; $display("FAIL rst_async_waitreq got=%b exp=1", cmd_waitreq); end
        checks++; if (cmd_data !== 32'd0)   begin errors++; $display("FAIL rst_async_data got=%h exp=0", cmd_data); end
        checks++; if (overflow !== 1'b0)    begin errors++; $display("FAIL rst_async_overflow got=%b exp=0", overflow); end
        tick();
        rst_n = 1'b1;
        send_word(32'hCAFE_F00D);
        checks++; if (fill_level !== 5'd1) begin errors++; $display("FAIL rst_fresh_fill got=%0d exp=1", fill_level); end
        pop();
        checks++; if (cmd_data !== 32'hCAFE_F00D) begin errors++; $display("FAIL rst_fresh_data got=%h exp=cafef00d", cmd_data); end
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        rst_n     = 1'b0;
        rx_data   = 8'h00;
        rx_valid  = 1'b0;
        cmd_rdreq = 1'b0;
        clr_flags = 1'b0;
        test_reset();
        test_basic();
        test_empty_pop();
        test_overflow();
        test_full_push_pop();
        test_empty_push_pop();
        test_timeout();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
